uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_bit_timer.sv | 35 +++
 rtl/uart_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing constants,
// used by both the receiver and the transmitter.
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int mid_offset(input int cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Clock-per-bit counter for the UART receiver. Produces a mid-bit tick and a
// full-bit tick; the counter wraps on the full-bit tick and restarts on clear.
module uart_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int MID_OFFSET   = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_mid_tick,
   output logic o_full_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(MID_OFFSET - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || (r_cnt == FULL_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_mid_tick  = (r_cnt == MID_LAST);
   assign o_full_tick = (r_cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized, edge-triggered start detection, mid-bit
// sampling, optional even/odd parity and one-cycle result pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_freq     = 200_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int P_data_width = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    RX_IN,
   input  logic                    PAR_EN,
   input  logic                    PAR_TYP,
   output logic [P_data_width-1:0] P_DATA,
   output logic                    DATA_VALID,
   output logic                    PAR_ERR,
   output logic                    STP_ERR,
   output logic                    Busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_freq, BAUD_RATE);
   localparam int MID_OFFSET   = mid_offset(CLKS_PER_BIT);
   localparam int BIT_W        = (P_data_width > 1) ? $clog2(P_data_width) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(P_data_width - 1);

   state_t                  r_state;
   logic                    r_sync1;
   logic                    r_sync2;
   logic                    r_prev;
   logic [P_data_width-1:0] r_shift;
   logic [BIT_W-1:0]        r_bit_idx;
   logic                    r_par_en;
   logic                    r_par_typ;
   logic                    r_par_bit;

   logic w_fall;
   logic w_mid_tick;
   logic w_full_tick;
   logic w_timer_clear;
   logic w_par_bad;
   logic w_stop_bad;

   // NOTE: synchronizer and edge flops reset to the idle-high level so that
   // releasing reset with the line idle never looks like a start edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= RX_IN;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall        = r_prev & ~r_sync2;
   assign w_timer_clear = (r_state == ST_IDLE) || ((r_state == ST_START) && w_mid_tick);
   assign w_par_bad     = r_par_en & ((^r_shift ^ r_par_bit) != r_par_typ);
   assign w_stop_bad    = ~r_sync2;
   assign Busy          = (r_state != ST_IDLE);

   uart_rx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .MID_OFFSET  (MID_OFFSET)
   ) u_bit_timer (
      .i_clk      (CLK),
      .i_rst_n    (RST),
      .i_clear    (w_timer_clear),
      .o_mid_tick (w_mid_tick),
      .o_full_tick(w_full_tick)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_bit  <= 1'b0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state   <= ST_START;
                  r_par_en  <= PAR_EN;
                  r_par_typ <= PAR_TYP;
               end
            end
            ST_START: begin
               if (w_mid_tick) begin
                  r_bit_idx <= '0;
                  r_state   <= r_sync2 ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_full_tick) begin
                  r_shift <= {r_sync2, r_shift[P_data_width-1:1]};
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= r_par_en ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + BIT_W'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (w_full_tick) begin
                  r_par_bit <= r_sync2;
                  r_state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Result is issued on the cycle following the stop-bit sample.
               if (w_full_tick) begin
                  r_state <= ST_IDLE;
                  PAR_ERR <= w_par_bad;
                  STP_ERR <= w_stop_bad;
                  if (!w_par_bad && !w_stop_bad) begin
                     P_DATA     <= r_shift;
                     DATA_VALID <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
